// File: rtl/dz_tx_scan.sv
// DZ-11 transmitter scanner: round-robins eight UART transmitters, parks on the first
// enabled-and-empty line, and turns a TDR write into a one-cycle load strobe for that line.
module dz_tx_scan #(
  parameter int unsigned HOLDOFF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       csrMSE,
  input  logic [7:0] tcrLIN,
  input  logic [7:0] uartTXEMPTY,
  input  logic       tdrWRITE,
  input  logic [7:0] tdrDATA,
  output logic [7:0] uartTXLOAD,
  output logic [7:0] uartTXDATA,
  output logic       csrTRDY,
  output logic [2:0] csrTLINE
);

  localparam logic [3:0] HoldInit = 4'(HOLDOFF);

  typedef enum logic [1:0] {
    StScan,
    StReady,
    StHold
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic       trdy_q, trdy_d;
  logic [2:0] tline_q, tline_d;
  logic [7:0] load_q, load_d;
  logic [7:0] data_q, data_d;
  logic [3:0] hold_q, hold_d;
  logic       wr_q;

  logic clear;
  logic wr;
  logic hit;

  assign clear = rst | clr;
  // Only the rising edge counts, so a held strobe produces a single load.
  assign wr    = tdrWRITE & ~wr_q;
  assign hit   = tcrLIN[ptr_q] & uartTXEMPTY[ptr_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    trdy_d  = trdy_q;
    tline_d = tline_q;
    load_d  = '0;
    data_d  = data_q;
    hold_d  = hold_q;

    case (state_q)
      StScan: begin
        trdy_d = 1'b0;
        if (csrMSE) begin
          if (hit) begin
            state_d = StReady;
            tline_d = ptr_q;
            trdy_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 3'd1;
          end
        end
      end

      StReady: begin
        // A write beats a simultaneous enable drop.
        if (wr) begin
          load_d  = 8'd1 << tline_q;
          data_d  = tdrDATA;
          trdy_d  = 1'b0;
          hold_d  = HoldInit;
          state_d = StHold;
        end else if (!tcrLIN[tline_q] || !csrMSE) begin
          trdy_d  = 1'b0;
          ptr_d   = tline_q + 3'd1;
          state_d = StScan;
        end
      end

      StHold: begin
        // Give the UART time to drop TXEMPTY; restart after the loaded line.
        if (hold_q <= 4'd1) begin
          ptr_d   = tline_q + 3'd1;
          state_d = StScan;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end

      default: begin
        state_d = StScan;
        trdy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StScan;
      ptr_q   <= '0;
      trdy_q  <= 1'b0;
      tline_q <= '0;
      load_q  <= '0;
      data_q  <= '0;
      hold_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      trdy_q  <= trdy_d;
      tline_q <= tline_d;
      load_q  <= load_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      wr_q    <= tdrWRITE;
    end
  end

  assign uartTXLOAD = load_q;
  assign uartTXDATA = data_q;
  assign csrTRDY    = trdy_q;
  assign csrTLINE   = tline_q;

  a_load_onehot0 : assert property (@(posedge clk) $onehot0(uartTXLOAD));
  a_load_not_ready : assert property (@(posedge clk) disable iff (clear)
    (uartTXLOAD != 8'd0) |-> !csrTRDY);

endmodule
